// File: rtl/fp_result_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_result_packer_if
// Purpose  : Vector handshake bundle between the FP add path and the packer.
// Revision : 1.0 - initial release
// ============================================================================
interface fp_result_packer_if #(
    parameter int NUM_LANES = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_LANES*32-1:0]   in_significand;
    logic [NUM_LANES*8-1:0]    in_exponent;
    logic [NUM_LANES-1:0]      in_sign;
    logic [NUM_LANES-1:0]      in_is_inf;
    logic [NUM_LANES-1:0]      in_is_nan;
    logic [NUM_LANES-1:0]      in_mask;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_LANES*32-1:0]   out_result;
    logic [NUM_LANES-1:0]      out_mask;

    modport master (
        output in_valid, in_significand, in_exponent, in_sign, in_is_inf,
               in_is_nan, in_mask, out_ready,
        input  in_ready, out_valid, out_result, out_mask
    );

    modport slave (
        input  in_valid, in_significand, in_exponent, in_sign, in_is_inf,
               in_is_nan, in_mask, out_ready,
        output in_ready, out_valid, out_result, out_mask
    );
endinterface
`default_nettype wire

// File: rtl/fp_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : fp_result_packer
// Purpose  : Normalizes and packs add-path results into IEEE singles,
//            LANES_PER_CYCLE lanes per cycle. FP_PACK_DENORMAL_EN enables
//            denormal outputs instead of flush-to-zero.
// Revision : 1.0 - initial release
// ============================================================================
module fp_result_packer #(
    parameter int NUM_LANES       = 16,
    parameter int LANES_PER_CYCLE = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fp_result_packer_if.slave  bus
);
    localparam int GROUPS = NUM_LANES / LANES_PER_CYCLE;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CONVERT = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

    logic [1:0]                      r_state;
    logic [CW-1:0]                   r_count;
    logic [NUM_LANES*25-1:0]         r_sig;
    logic [NUM_LANES*8-1:0]          r_exp;
    logic [NUM_LANES-1:0]            r_sign;
    logic [NUM_LANES-1:0]            r_inf;
    logic [NUM_LANES-1:0]            r_nan;
    logic                            r_out_valid;
    logic [NUM_LANES*32-1:0]         r_out_result;
    logic [NUM_LANES-1:0]            r_out_mask;

    logic [NUM_LANES*25-1:0]         w_sig_trim;
    logic [LANES_PER_CYCLE*32-1:0]   w_packed;
    logic                            w_in_ready;
    logic                            w_accept;
    int                              w_base;

    function automatic logic [31:0] pack_lane(
        input logic [24:0] sig,
        input logic [7:0]  exp,
        input logic        sign,
        input logic        inf,
        input logic        nan
    );
        logic [23:0]       norm;
        logic signed [9:0] e;
        logic [4:0]        lz;
        logic [31:0]       res;
`ifdef FP_PACK_DENORMAL_EN
        logic signed [9:0] sh;
        logic [23:0]       den;
`endif
        norm = '0;
        e    = '0;
        lz   = '0;
        res  = '0;
        if (nan) begin
            res = 32'h7FFF_FFFF;
        end else if (inf) begin
            res = {sign, 8'hFF, 23'h0};
        end else if (sig != 25'h0) begin
            if (sig[24]) begin
                norm = sig[24:1];
                e    = $signed({2'b00, exp}) + 10'sd1;
            end else begin
                // Highest set bit is visited last and determines the count.
                for (int b = 0; b < 24; b++) begin
                    if (sig[b]) lz = 5'(23 - b);
                end
                norm = sig[23:0] << lz;
                e    = $signed({2'b00, exp}) - $signed({5'b00000, lz});
            end
            if (e >= 10'sd255) begin
                res = {sign, 8'hFF, 23'h0};
            end else if (e <= 10'sd0) begin
`ifdef FP_PACK_DENORMAL_EN
                if (e >= -10'sd22) begin
                    sh  = 10'sd1 - e;
                    den = norm >> sh[4:0];
                    res = {sign, 8'h00, den[22:0]};
                end else begin
                    res = {sign, 31'h0};
                end
`else
                res = {sign, 31'h0};
`endif
            end else begin
                res = {sign, e[7:0], norm[22:0]};
            end
        end
        return res;
    endfunction

    // Bits above the carry position never reach the packer.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_trim
        assign w_sig_trim[l*25 +: 25] = bus.in_significand[l*32 +: 25];
    end

    assign w_in_ready = (r_state == c_IDLE) || ((r_state == c_DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_base     = int'(r_count) * LANES_PER_CYCLE;

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_mask   = r_out_mask;

    always_comb begin
        w_packed = '0;
        for (int i = 0; i < LANES_PER_CYCLE; i++) begin
            w_packed[i*32 +: 32] = pack_lane(r_sig[(w_base+i)*25 +: 25],
                                             r_exp[(w_base+i)*8 +: 8],
                                             r_sign[w_base+i],
                                             r_inf[w_base+i],
                                             r_nan[w_base+i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_count      <= '0;
            r_sig        <= '0;
            r_exp        <= '0;
            r_sign       <= '0;
            r_inf        <= '0;
            r_nan        <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_mask   <= '0;
        end else if (w_accept) begin
            r_sig       <= w_sig_trim;
            r_exp       <= bus.in_exponent;
            r_sign      <= bus.in_sign;
            r_inf       <= bus.in_is_inf;
            r_nan       <= bus.in_is_nan;
            r_out_mask  <= bus.in_mask;
            r_count     <= '0;
            r_state     <= c_CONVERT;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_CONVERT: begin
                    for (int i = 0; i < LANES_PER_CYCLE; i++) begin
                        r_out_result[(w_base+i)*32 +: 32] <= w_packed[i*32 +: 32];
                    end
                    if (r_count == CW'(GROUPS - 1)) begin
                        r_state     <= c_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= c_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
